// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART memory dumper.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS            = 8;
    localparam int BYTES_PER_WORD       = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter; tick marks the last cycle of each UART bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = (cnt == 16'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) cnt <= 16'd0;
        else cnt <= tick ? 16'd0 : cnt + 16'd1;
    end

endmodule

// File: rtl/uart_mem_dump.sv
// uart_mem_dump: reads a block of 32-bit words from memory and streams them out as 8N1 UART bytes.
module uart_mem_dump
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [13:0] base_adr_i,
    input  logic [14:0] word_cnt_i,
    output logic        mem_ren_o,
    output logic [13:0] mem_adr_o,
    input  logic [31:0] mem_dat_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    state_t      state;
    logic [14:0] rem;
    logic [31:0] shift;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic        tick;

    // The bit counter idles at zero outside a frame, so every frame begins with a full bit period.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(!(state inside {S_START_BIT, S_DATA_BITS, S_STOP_BIT})),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rem       <= 15'd0;
            shift     <= 32'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            mem_ren_o <= 1'b0;
            mem_adr_o <= 14'd0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            mem_ren_o <= 1'b0;
            done_o    <= 1'b0;
            // Line level is registered from the state of the previous cycle.
            tx_o      <= (state == S_START_BIT) ? 1'b0 : (state == S_DATA_BITS) ? shift[0] : 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (word_cnt_i == 15'd0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= S_READ;
                            rem       <= word_cnt_i;
                            mem_ren_o <= 1'b1;
                            mem_adr_o <= base_adr_i;
                            busy_o    <= 1'b1;
                        end
                    end
                end
                S_READ: state <= S_CAPTURE;
                S_CAPTURE: begin
                    shift    <= mem_dat_i;
                    byte_idx <= 2'd0;
                    state    <= S_START_BIT;
                end
                S_START_BIT: begin
                    if (tick) begin
                        bit_idx <= 3'd0;
                        state   <= S_DATA_BITS;
                    end
                end
                S_DATA_BITS: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= S_STOP_BIT;
                    end
                end
                S_STOP_BIT: begin
                    if (tick) begin
                        if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_START_BIT;
                        end else begin
                            rem <= rem - 15'd1;
                            if (rem != 15'd1) begin
                                state     <= S_READ;
                                mem_ren_o <= 1'b1;
                                mem_adr_o <= mem_adr_o + 14'd1;
                            end else begin
                                state  <= S_DONE;
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb_uart_mem_dump: randomized scoreboard bench with a UART receiver monitor and a word-level reference model.
module tb_uart_mem_dump;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [13:0] base_adr_i = 14'd0;
    logic [14:0] word_cnt_i = 15'd0;
    logic        mem_ren_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat_i = 32'd0;
    logic        tx_o, busy_o, done_o;

    uart_mem_dump #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .base_adr_i(base_adr_i),
        .word_cnt_i(word_cnt_i),
        .mem_ren_o (mem_ren_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_i (mem_dat_i),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    always @(posedge clk) mem_dat_i <= mem_ren_o ? mem[mem_adr_o] : $urandom;

    int checks = 0, failures = 0, ncyc = 0, done_count = 0, ren_count = 0;
    logic [7:0]  exp_bytes[$];
    logic [13:0] exp_adr[$];
    int          frame_n[$];

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done_o) done_count++;
        if (!rst && mem_ren_o) begin
            ren_count++;
            if (exp_adr.size() == 0) check("unexpected_read", 32'(mem_adr_o), 32'hFFFFFFFF);
            else check("read_adr", 32'(mem_adr_o), 32'(exp_adr.pop_front()));
        end
    end

    // UART receiver: samples mid-bit and scores each received byte against the expected stream.
    initial begin : rx
        logic       prev;
        logic [7:0] b;
        logic       start_bit, stop_bit;
        bit         ab;
        int         j;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !tx_o) begin
                frame_n.push_back(ncyc);
                ab = 0;
                b = 8'd0;
                start_bit = 1'b1;
                stop_bit = 1'b0;
                for (int k = 1; k <= C / 2 + 9 * C && !ab; k++) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                    else if (k >= C / 2 && (k - C / 2) % C == 0) begin
                        j = (k - C / 2) / C;
                        if (j == 0) start_bit = tx_o;
                        else if (j <= 8) b[j-1] = tx_o;
                        else stop_bit = tx_o;
                    end
                end
                if (!ab) begin
                    check("start_bit", 32'(start_bit), 32'd0);
                    check("stop_bit", 32'(stop_bit), 32'd1);
                    if (exp_bytes.size() == 0) check("unexpected_byte", 32'(b), 32'hFFFFFFFF);
                    else check("rx_byte", 32'(b), 32'(exp_bytes.pop_front()));
                end
            end
            prev = tx_o;
        end
    end

    function automatic int low_cycles(input logic [13:0] b, input logic [14:0] c);
        int s;
        logic [31:0] w;
        s = 0;
        for (int i = 0; i < int'(c); i++) begin
            w = mem[b + 14'(i)];
            s += (4 + 32 - $countones(w)) * C;
        end
        return s;
    endfunction

    function automatic int done_time(input logic [14:0] c);
        return 40 * C + 3 + (int'(c) - 1) * (40 * C + 2);
    endfunction

    task automatic go(input logic [13:0] b, input logic [14:0] c, input int poke_n, input int rst_n,
                      output int t_fall, output int t_done, output int lows, output int dones);
        int budget, d0;
        logic [13:0] a;
        budget = (int'(c) + 1) * 50 * C + 40;
        d0 = done_count;
        for (int w = 0; w < int'(c); w++) begin
            a = b + 14'(w);
            exp_adr.push_back(a);
            for (int k = 0; k < 4; k++) exp_bytes.push_back(mem[a][8*k +: 8]);
        end
        frame_n.delete();
        t_fall = -1;
        t_done = -1;
        lows = 0;
        @(negedge clk);
        start_i = 1'b1;
        base_adr_i = b;
        word_cnt_i = c;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            start_i = (n == poke_n);
            if (n == poke_n) begin
                base_adr_i = 14'($urandom);
                word_cnt_i = 15'($urandom_range(1, 7));
            end
            if (!tx_o) begin
                lows++;
                if (t_fall < 0) t_fall = n;
            end
            if (done_o && t_done < 0) t_done = n;
            if (rst_n > 0 && n == rst_n) rst = 1'b1;
            if (rst_n > 0 && n == rst_n + 1) begin
                check("rst_tx", 32'(tx_o), 32'd1);
                check("rst_busy", 32'(busy_o), 32'd0);
                check("rst_done", 32'(done_o), 32'd0);
                check("rst_ren", 32'(mem_ren_o), 32'd0);
                exp_bytes.delete();
                exp_adr.delete();
            end
            if (rst_n > 0 && n == rst_n + 2) rst = 1'b0;
            if (rst_n > 0 && n == rst_n + 12) break;
            if (t_done > 0 && n == t_done + 4) break;
        end
        if (rst_n <= 0) check("done_seen", 32'(t_done > 0), 32'd1);
        dones = done_count - d0;
    endtask

    initial begin
        int tf, td, lw, dn, r0;
        logic [13:0] b;
        logic [14:0] c;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[16'h0010] = 32'hA55A0F01;

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_ren", 32'(mem_ren_o), 32'd0);
        check("reset_adr", 32'(mem_adr_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        go(14'h0010, 15'd1, 0, 0, tf, td, lw, dn);
        check("w1_tx_fall", 32'(tf), 32'd4);
        check("w1_done_time", 32'(td), 32'(done_time(15'd1)));
        check("w1_low_cycles", 32'(lw), 32'(low_cycles(14'h0010, 15'd1)));
        check("w1_dones", 32'(dn), 32'd1);
        check("w1_frames", 32'(frame_n.size()), 32'd4);
        check("w1_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("w1_busy_after", 32'(busy_o), 32'd0);

        r0 = ren_count;
        go(14'($urandom), 15'd0, 0, 0, tf, td, lw, dn);
        check("c0_done_time", 32'(td), 32'd1);
        check("c0_tx_low", 32'(lw), 32'd0);
        check("c0_reads", 32'(ren_count - r0), 32'd0);
        check("c0_dones", 32'(dn), 32'd1);

        r0 = ren_count;
        go(14'h3FFF, 15'd2, 0, 0, tf, td, lw, dn);
        check("wrap_reads", 32'(ren_count - r0), 32'd2);
        check("wrap_done_time", 32'(td), 32'(done_time(15'd2)));
        check("wrap_frames", 32'(frame_n.size()), 32'd8);
        if (frame_n.size() == 8) begin
            check("wrap_byte_gap", 32'(frame_n[3] - frame_n[2]), 32'(10 * C));
            check("wrap_word_gap", 32'(frame_n[4] - frame_n[3]), 32'(10 * C + 2));
        end
        check("wrap_bytes_left", 32'(exp_bytes.size()), 32'd0);

        r0 = ren_count;
        b = 14'($urandom);
        go(b, 15'd3, 100, 0, tf, td, lw, dn);
        check("poke_reads", 32'(ren_count - r0), 32'd3);
        check("poke_dones", 32'(dn), 32'd1);
        check("poke_frames", 32'(frame_n.size()), 32'd12);
        check("poke_done_time", 32'(td), 32'(done_time(15'd3)));
        check("poke_bytes_left", 32'(exp_bytes.size()), 32'd0);

        go(14'($urandom), 15'd1, 0, 56, tf, td, lw, dn);
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        b = 14'($urandom);
        go(b, 15'd1, 0, 0, tf, td, lw, dn);
        check("after_rst_done_time", 32'(td), 32'(done_time(15'd1)));
        check("after_rst_low", 32'(lw), 32'(low_cycles(b, 15'd1)));
        check("after_rst_dones", 32'(dn), 32'd1);
        check("after_rst_bytes_left", 32'(exp_bytes.size()), 32'd0);

        for (int t = 0; t < 4; t++) begin
            b = 14'($urandom);
            if (t == 0) b = 14'h3FFE;
            c = 15'($urandom_range(1, 3));
            go(b, c, 0, 0, tf, td, lw, dn);
            check("rand_tx_fall", 32'(tf), 32'd4);
            check("rand_done_time", 32'(td), 32'(done_time(c)));
            check("rand_low", 32'(lw), 32'(low_cycles(b, c)));
            check("rand_dones", 32'(dn), 32'd1);
            check("rand_bytes_left", 32'(exp_bytes.size()), 32'd0);
            check("rand_adr_left", 32'(exp_adr.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mem_dump.md
UART_MEM_DUMP -- requirements
Module: uart_mem_dump

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  one-cycle request to begin a dump.
REQ-005 SHALL have port base_adr_i  input  14  first word address, sampled with start_i.
REQ-006 SHALL have port word_cnt_i  input  15  number of 32-bit words to send, sampled with start_i.
REQ-007 SHALL have port mem_ren_o  output  1  memory read strobe.
REQ-008 SHALL have port mem_adr_o  output  14  memory word address.
REQ-009 SHALL have port mem_dat_i  input  32  read data, valid in the cycle after mem_ren_o.
REQ-010 SHALL have port tx_o  output  1  UART serial line, 8N1, idle high.
REQ-011 SHALL have port busy_o  output  1  high from the cycle after an accepted start until done_o.
REQ-012 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, READ, CAPTURE, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-014 SHALL accept start_i only in IDLE; start_i in any other state is ignored, with no queuing.
REQ-015 SHALL, on start_i at edge N with word_cnt_i!=0, latch base/count, enter READ and drive mem_ren_o=1 and mem_adr_o=current address during cycle N+1 only.
REQ-016 SHALL, in CAPTURE (cycle N+2), load mem_dat_i into a 32-bit shift word, then enter START_BIT, so tx_o falls at edge N+3.
REQ-017 SHALL send each word as 4 bytes, LSB byte first, with each byte's bits LSB first.
REQ-018 SHALL frame each byte as 1 start bit (0), 8 data bits and 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-019 SHALL start the next byte of a word immediately after a stop bit, with no idle gap.
REQ-020 SHALL, after the stop bit of byte 3, decrement the remaining count and go to READ for the next address (2 idle-high cycles between words) if count!=0; otherwise go to DONE.
REQ-021 SHALL increment the address modulo 2^14 (0x3FFF -> 0x0000).
REQ-022 SHALL, in DONE, assert done_o for exactly one cycle, deassert busy_o in that same cycle, then return to IDLE.
REQ-023 SHALL, for word_cnt_i=0, go IDLE->DONE: done_o high in cycle N+1, no mem_ren_o, tx_o held at 1.
REQ-024 SHALL drive tx_o from a register (glitch-free), =1 in all states other than START_BIT, DATA_BITS and STOP_BIT.
REQ-025 SHALL hold mem_adr_o at the last issued address whenever mem_ren_o=0.

Reset
REQ-026 SHALL, on rst sampled high, enter IDLE at that edge with tx_o=1, busy_o=0, done_o=0, mem_ren_o=0, mem_adr_o=0, counters=0.
REQ-027 SHALL give rst priority over start_i; reset mid-frame SHALL abort the frame without a done_o pulse.

Structure
REQ-028 SHALL place the state enum, the default CLKS_PER_BIT value and frame constants (DATA_BITS=8, BYTES_PER_WORD=4) in a shared package, uart_pkg.
REQ-029 SHALL instantiate a single sub-module, uart_baud_cnt, which generates the bit-end tick and restarts on every frame start.

Verification (CLKS_PER_BIT=4)
REQ-030 SHALL check: mem[0x0010]=0xA55A0F01, base=0x0010, cnt=1 -> tx bytes 0x01,0x0F,0x5A,0xA5; 160 tx cycles; done_o at the cycle after the last stop bit ends.
REQ-031 SHALL check: cnt=0 -> done_o high exactly 1 cycle after start; mem_ren_o never high; tx_o constant 1.
REQ-032 SHALL check: base=0x3FFF, cnt=2 -> reads at 0x3FFF then 0x0000; 2 idle-high cycles between words.
REQ-033 SHALL check: start_i pulsed mid-transfer of cnt=3 -> exactly 3 words sent and 1 done_o pulse.
REQ-034 SHALL check: rst during DATA_BITS of byte 1 -> next cycle tx_o=1, busy_o=0, no done_o; a following start (cnt=1) transmits correctly.
